// File: rtl/sdram_req_arbiter_if.sv
// sdram_req_arbiter_if
//   Command/response channel between the request arbiter and the SDRAM core.
//   master : arbiter side (drives cmd_*, receives cmd_ready and rsp_*)
//   slave  : core side
//   cmd_valid/cmd_ready : single-command handshake
//   cmd_we/addr/din/ds  : command payload, cmd_src = granted source index
//   rsp_valid/rsp_data  : read data return for the outstanding read
interface sdram_req_arbiter_if #(parameter int AW = 22);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [15:0]   cmd_din;
  logic [1:0]    cmd_ds;
  logic [1:0]    cmd_src;
  logic          rsp_valid;
  logic [15:0]   rsp_data;

  modport master (
    output cmd_valid, cmd_we, cmd_addr, cmd_din, cmd_ds, cmd_src,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_we, cmd_addr, cmd_din, cmd_ds, cmd_src,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/sdram_req_arbiter.sv
// sdram_req_arbiter
//   Shares one SDRAM command port among four requesters (0=cpu, 1=aram,
//   2=vram, 3=rv). Single-cycle request strobes are latched per source,
//   one command is granted at a time (fixed priority, lowest index first,
//   with an rv anti-starvation override) and read data is routed back to
//   the owner with a one-cycle done pulse.
//   Ports:
//     clk, reset          : clock, asynchronous active-high reset
//     req/we/addr/din/ds  : per-source request strobe and payload slices
//     pending             : source has a request outstanding
//     done                : one-cycle completion pulse per source
//     dout                : per-source read data register (16 bits/source)
//     overrun             : sticky, request dropped because source was busy
//     rsp_err             : sticky, read data arrived with no read in flight
//     cmd                 : command/response channel to the SDRAM core

// Per-source request slot: holds the latched request and its pending flag.
module sdram_req_slot #(parameter int AW = 22) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [15:0]   req_din,
  input  logic [1:0]    req_ds,
  input  logic          complete,
  output logic          pending,
  output logic          overrun,
  output logic          hold_we,
  output logic [AW-1:0] hold_addr,
  output logic [15:0]   hold_din,
  output logic [1:0]    hold_ds
);
  logic accept;

  // A source whose transaction finishes this cycle may queue its next one.
  assign accept = req & (~pending | complete);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending   <= 1'b0;
      overrun   <= 1'b0;
      hold_we   <= 1'b0;
      hold_addr <= '0;
      hold_din  <= '0;
      hold_ds   <= '0;
    end else begin
      if (accept) begin
        hold_we   <= req_we;
        hold_addr <= req_addr;
        hold_din  <= req_din;
        hold_ds   <= req_ds;
      end
      if (req && pending && !complete) overrun <= 1'b1;
      pending <= accept | (pending & ~complete);
    end
  end
endmodule

module sdram_req_arbiter #(
  parameter int AW          = 22,
  parameter int RV_MAX_WAIT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            req,
  input  logic [3:0]            we,
  input  logic [4*AW-1:0]       addr,
  input  logic [63:0]           din,
  input  logic [7:0]            ds,
  output logic [3:0]            pending,
  output logic [3:0]            done,
  output logic [63:0]           dout,
  output logic [3:0]            overrun,
  output logic                  rsp_err,
  sdram_req_arbiter_if.master   cmd
);
  localparam logic [7:0] RV_MAX = 8'(RV_MAX_WAIT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_t;

  state_t               state, state_nxt;
  logic [3:0]           hold_we;
  logic [3:0][AW-1:0]   hold_addr;
  logic [3:0][15:0]     hold_din;
  logic [3:0][1:0]      hold_ds;
  logic [3:0]           complete;
  logic [1:0]           grant;
  logic                 grant_vld;
  logic [7:0]           starve;

  generate
    for (genvar i = 0; i < 4; i++) begin : g_slot
      sdram_req_slot #(.AW(AW)) u_slot (
        .clk       (clk),
        .reset     (reset),
        .req       (req[i]),
        .req_we    (we[i]),
        .req_addr  (addr[i*AW +: AW]),
        .req_din   (din[i*16 +: 16]),
        .req_ds    (ds[i*2 +: 2]),
        .complete  (complete[i]),
        .pending   (pending[i]),
        .overrun   (overrun[i]),
        .hold_we   (hold_we[i]),
        .hold_addr (hold_addr[i]),
        .hold_din  (hold_din[i]),
        .hold_ds   (hold_ds[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 2'd0;
    grant_vld = 1'b0;
    complete  = '0;
    // Lowest pending index wins unless rv has waited long enough.
    for (int i = 3; i >= 0; i--) if (pending[i]) grant = 2'(i);
    if (pending[3] && starve >= RV_MAX) grant = 2'd3;
    unique case (state)
      IDLE: begin
        if (|pending) begin
          grant_vld = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (cmd.cmd_ready) begin
          if (cmd.cmd_we) begin
            complete[cmd.cmd_src] = 1'b1;
            state_nxt             = IDLE;
          end else begin
            state_nxt = WAIT_RSP;
          end
        end
      end
      WAIT_RSP: begin
        if (cmd.rsp_valid) begin
          complete[cmd.cmd_src] = 1'b1;
          state_nxt             = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd.cmd_valid <= 1'b0;
      cmd.cmd_we    <= 1'b0;
      cmd.cmd_addr  <= '0;
      cmd.cmd_din   <= '0;
      cmd.cmd_ds    <= '0;
      cmd.cmd_src   <= '0;
      done          <= '0;
      dout          <= '0;
      rsp_err       <= 1'b0;
      starve        <= '0;
    end else begin
      done <= complete;
      if (grant_vld) begin
        cmd.cmd_valid <= 1'b1;
        cmd.cmd_we    <= hold_we[grant];
        cmd.cmd_addr  <= hold_addr[grant];
        cmd.cmd_din   <= hold_din[grant];
        cmd.cmd_ds    <= hold_ds[grant];
        cmd.cmd_src   <= grant;
      end else if (state == ISSUE && cmd.cmd_ready) begin
        cmd.cmd_valid <= 1'b0;
      end
      if (state == WAIT_RSP && cmd.rsp_valid)
        dout[{cmd.cmd_src, 4'b0000} +: 16] <= cmd.rsp_data;
      if (cmd.rsp_valid && state != WAIT_RSP) rsp_err <= 1'b1;
      // Count only grants that bypassed a waiting rv; clear once rv is idle.
      if (!pending[3])
        starve <= '0;
      else if (grant_vld)
        starve <= (grant == 2'd3) ? 8'd0 :
                  (starve >= RV_MAX) ? RV_MAX : starve + 8'd1;
    end
  end
endmodule

// File: tb/tb_sdram_req_arbiter.sv
// tb_sdram_req_arbiter
//   Directed scenarios with hand-derived expectations, then a randomized run
//   against a cycle-level reference model of the arbitration rules.
module tb_sdram_req_arbiter;
  localparam int AW = 22;
  localparam int RV = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [3:0]      req, we;
  logic [4*AW-1:0] addr;
  logic [63:0]     din;
  logic [7:0]      ds;
  logic [3:0]      pending, done, overrun;
  logic [63:0]     dout;
  logic            rsp_err;
  int              tests = 0;
  int              fails = 0;

  sdram_req_arbiter_if #(.AW(AW)) cif ();

  sdram_req_arbiter #(.AW(AW), .RV_MAX_WAIT(RV)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .we      (we),
    .addr    (addr),
    .din     (din),
    .ds      (ds),
    .pending (pending),
    .done    (done),
    .dout    (dout),
    .overrun (overrun),
    .rsp_err (rsp_err),
    .cmd     (cif)
  );

  always #5 clk = ~clk;

  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    tests++; if (pending !== 4'b0) begin fails++; $display("FAIL rst_pending got %b want 0000", pending); end
    tests++; if (cif.cmd_valid !== 1'b0) begin fails++; $display("FAIL rst_cmd_valid got %b want 0", cif.cmd_valid); end
    tests++; if (done !== 4'b0) begin fails++; $display("FAIL rst_done got %b want 0000", done); end
    tests++; if (dout !== 64'b0) begin fails++; $display("FAIL rst_dout got %h want 0", dout); end
    tests++; if ({overrun, rsp_err} !== 5'b0) begin fails++; $display("FAIL rst_sticky got %b want 00000", {overrun, rsp_err}); end
    reset = 1'b0;
  endtask

  task automatic test_single_read;
    @(negedge clk);  // cycle 0
    req = 4'b0001; we = 4'b0000; addr[0 +: AW] = 22'h012345; cif.cmd_ready = 1'b1;
    @(negedge clk);  // cycle 1
    req = 4'b0;
    tests++; if (pending !== 4'b0001) begin fails++; $display("FAIL rd_pending got %b want 0001", pending); end
    tests++; if (cif.cmd_valid !== 1'b0) begin fails++; $display("FAIL rd_valid_c1 got %b want 0", cif.cmd_valid); end
    @(negedge clk);  // cycle 2
    tests++; if (cif.cmd_valid !== 1'b1) begin fails++; $display("FAIL rd_valid_c2 got %b want 1", cif.cmd_valid); end
    tests++; if (cif.cmd_src !== 2'd0) begin fails++; $display("FAIL rd_src got %0d want 0", cif.cmd_src); end
    tests++; if (cif.cmd_addr !== 22'h012345) begin fails++; $display("FAIL rd_addr got %h want 012345", cif.cmd_addr); end
    tests++; if (cif.cmd_we !== 1'b0) begin fails++; $display("FAIL rd_we got %b want 0", cif.cmd_we); end
    @(negedge clk);  // cycle 3
    tests++; if (cif.cmd_valid !== 1'b0) begin fails++; $display("FAIL rd_valid_c3 got %b want 0", cif.cmd_valid); end
    @(negedge clk);  // cycle 4
    @(negedge clk);  // cycle 5
    tests++; if (done !== 4'b0) begin fails++; $display("FAIL rd_done_early got %b want 0000", done); end
    cif.rsp_valid = 1'b1; cif.rsp_data = 16'hBEEF;
    @(negedge clk);  // cycle 6
    cif.rsp_valid = 1'b0;
    tests++; if (done !== 4'b0001) begin fails++; $display("FAIL rd_done got %b want 0001", done); end
    tests++; if (dout[15:0] !== 16'hBEEF) begin fails++; $display("FAIL rd_dout got %h want beef", dout[15:0]); end
    tests++; if (pending !== 4'b0) begin fails++; $display("FAIL rd_pending_clr got %b want 0000", pending); end
    @(negedge clk);
    tests++; if (done !== 4'b0) begin fails++; $display("FAIL rd_done_pulse got %b want 0000", done); end
  endtask

  task automatic test_all_writes;
    logic       ev;
    logic [1:0] es;
    logic [3:0] ed, ep;
    @(negedge clk);  // cycle 0
    req = 4'b1111; we = 4'b1111; cif.cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr[i*AW +: AW] = AW'(22'h100 + i);
      din[i*16 +: 16]  = 16'(16'hA000 + i);
    end
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      req = 4'b0;
      ev = (c >= 2 && c <= 8 && c % 2 == 0);
      es = 2'((c - 2) / 2);
      ed = (c >= 3 && c <= 9 && c % 2 == 1) ? 4'(1 << ((c - 3) / 2)) : 4'b0;
      for (int s = 0; s < 4; s++) ep[s] = (c < 3 + 2 * s);
      tests++; if (cif.cmd_valid !== ev) begin fails++; $display("FAIL wr4_valid c%0d got %b want %b", c, cif.cmd_valid, ev); end
      tests++; if (done !== ed) begin fails++; $display("FAIL wr4_done c%0d got %b want %b", c, done, ed); end
      tests++; if (pending !== ep) begin fails++; $display("FAIL wr4_pending c%0d got %b want %b", c, pending, ep); end
      if (ev) begin
        tests++; if (cif.cmd_src !== es) begin fails++; $display("FAIL wr4_src c%0d got %0d want %0d", c, cif.cmd_src, es); end
        tests++; if (cif.cmd_din !== 16'(16'hA000 + es)) begin fails++; $display("FAIL wr4_din c%0d got %h want %h", c, cif.cmd_din, 16'(16'hA000 + es)); end
      end
    end
  endtask

  task automatic test_starvation;
    int   g[$];
    int   exp1 [11] = '{0, 1, 0, 1, 0, 1, 0, 1, 3, 0, 1};
    int   exp2 [3]  = '{0, 1, 3};
    logic pv;
    logic fin;
    @(negedge clk);
    req = 4'b1011; we = 4'b1111; cif.cmd_ready = 1'b1;
    pv = 1'b0; fin = 1'b0;
    for (int c = 0; c < 80 && !fin; c++) begin
      @(negedge clk);
      req = 4'b0;
      if (cif.cmd_valid && !pv) g.push_back(int'(cif.cmd_src));
      pv = cif.cmd_valid;
      // cpu and aram come straight back as soon as they finish, until rv is served
      if (g.size() < 9) begin
        if (done[0]) req[0] = 1'b1;
        if (done[1]) req[1] = 1'b1;
      end
      if (g.size() >= 11 && pending == 4'b0 && !cif.cmd_valid) fin = 1'b1;
    end
    tests++; if (!fin || g.size() != 11) begin fails++; $display("FAIL starve_count got %0d grants want 11", g.size()); end
    else for (int k = 0; k < 11; k++) begin
      tests++; if (g[k] != exp1[k]) begin fails++; $display("FAIL starve_order[%0d] got %0d want %0d", k, g[k], exp1[k]); end
    end
    // Counter must be back at zero: a fresh rv request waits behind cpu/aram again.
    g.delete();
    @(negedge clk);
    req = 4'b1011; pv = 1'b0; fin = 1'b0;
    for (int c = 0; c < 40 && !fin; c++) begin
      @(negedge clk);
      req = 4'b0;
      if (cif.cmd_valid && !pv) g.push_back(int'(cif.cmd_src));
      pv = cif.cmd_valid;
      if (g.size() >= 3 && pending == 4'b0 && !cif.cmd_valid) fin = 1'b1;
    end
    tests++; if (!fin || g.size() != 3) begin fails++; $display("FAIL starve_r2_count got %0d grants want 3", g.size()); end
    else for (int k = 0; k < 3; k++) begin
      tests++; if (g[k] != exp2[k]) begin fails++; $display("FAIL starve_r2_order[%0d] got %0d want %0d", k, g[k], exp2[k]); end
    end
  endtask

  task automatic test_stall;
    int nd = 0;
    @(negedge clk);  // cycle 0
    req = 4'b0100; we = 4'b0100; cif.cmd_ready = 1'b0;
    addr[2*AW +: AW] = 22'h2ABCDE; din[32 +: 16] = 16'h1234; ds[4 +: 2] = 2'b00;
    @(negedge clk);  // cycle 1
    req = 4'b0;
    addr[2*AW +: AW] = 22'h155555; din[32 +: 16] = 16'hFFFF; ds[4 +: 2] = 2'b11;
    for (int c = 2; c <= 10; c++) begin
      @(negedge clk);
      if (done[2]) nd++;
      if (c <= 6) begin
        tests++; if (cif.cmd_valid !== 1'b1) begin fails++; $display("FAIL stall_valid c%0d got %b want 1", c, cif.cmd_valid); end
        tests++; if ({cif.cmd_we, cif.cmd_src, cif.cmd_ds} !== 5'b1_10_00) begin fails++; $display("FAIL stall_ctl c%0d got %b want 11000", c, {cif.cmd_we, cif.cmd_src, cif.cmd_ds}); end
        tests++; if (cif.cmd_addr !== 22'h2ABCDE) begin fails++; $display("FAIL stall_addr c%0d got %h want 2abcde", c, cif.cmd_addr); end
        tests++; if (cif.cmd_din !== 16'h1234) begin fails++; $display("FAIL stall_din c%0d got %h want 1234", c, cif.cmd_din); end
      end
      if (c == 6) cif.cmd_ready = 1'b1;
      if (c == 7) begin
        tests++; if (done !== 4'b0100) begin fails++; $display("FAIL stall_done got %b want 0100", done); end
        tests++; if (cif.cmd_valid !== 1'b0) begin fails++; $display("FAIL stall_drop got %b want 0", cif.cmd_valid); end
      end
    end
    tests++; if (nd != 1) begin fails++; $display("FAIL stall_ndone got %0d want 1", nd); end
  endtask

  task automatic test_overrun;
    @(negedge clk);  // cycle 0
    req = 4'b0100; we = 4'b0100; cif.cmd_ready = 1'b0; addr[2*AW +: AW] = 22'h000222;
    @(negedge clk);  // cycle 1
    req = 4'b0;
    @(negedge clk);  // cycle 2: second request while still pending
    req = 4'b0100; addr[2*AW +: AW] = 22'h000333;
    @(negedge clk);  // cycle 3
    req = 4'b0;
    tests++; if (overrun !== 4'b0100) begin fails++; $display("FAIL ovr_set got %b want 0100", overrun); end
    tests++; if (pending !== 4'b0100) begin fails++; $display("FAIL ovr_pending got %b want 0100", pending); end
    tests++; if (cif.cmd_addr !== 22'h000222) begin fails++; $display("FAIL ovr_keep got %h want 000222", cif.cmd_addr); end
    cif.cmd_ready = 1'b1;
    @(negedge clk);  // cycle 4: completion visible, re-request now
    tests++; if (done !== 4'b0100) begin fails++; $display("FAIL ovr_done got %b want 0100", done); end
    req = 4'b0100; addr[2*AW +: AW] = 22'h000444;
    @(negedge clk);  // cycle 5
    req = 4'b0;
    tests++; if (pending !== 4'b0100) begin fails++; $display("FAIL ovr_reacc got %b want 0100", pending); end
    tests++; if (overrun !== 4'b0100) begin fails++; $display("FAIL ovr_sticky got %b want 0100", overrun); end
    @(negedge clk);  // cycle 6
    tests++; if (cif.cmd_addr !== 22'h000444 || cif.cmd_valid !== 1'b1) begin fails++; $display("FAIL ovr_newcmd got %h/%b want 000444/1", cif.cmd_addr, cif.cmd_valid); end
    @(negedge clk);  // cycle 7
    tests++; if (done !== 4'b0100) begin fails++; $display("FAIL ovr_done2 got %b want 0100", done); end
  endtask

  task automatic test_rsp_err;
    @(negedge clk);
    cif.rsp_valid = 1'b1; cif.rsp_data = 16'hDEAD;
    @(negedge clk);
    cif.rsp_valid = 1'b0;
    tests++; if (rsp_err !== 1'b1) begin fails++; $display("FAIL rsperr_set got %b want 1", rsp_err); end
    tests++; if (done !== 4'b0 || pending !== 4'b0) begin fails++; $display("FAIL rsperr_quiet got %b/%b want 0000/0000", done, pending); end
    @(negedge clk);
    tests++; if (done !== 4'b0 || rsp_err !== 1'b1) begin fails++; $display("FAIL rsperr_hold got %b/%b want 0000/1", done, rsp_err); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);  // cycle 0
    req = 4'b0010; we = 4'b0000; cif.cmd_ready = 1'b1; addr[AW +: AW] = 22'h000777;
    @(negedge clk);  // cycle 1
    req = 4'b0;
    @(negedge clk);  // cycle 2: read accepted at next edge
    @(negedge clk);  // cycle 3: waiting for data
    tests++; if (pending !== 4'b0010 || cif.cmd_valid !== 1'b0) begin fails++; $display("FAIL rmid_wait got %b/%b want 0010/0", pending, cif.cmd_valid); end
    reset = 1'b1;
    #1;
    tests++; if (pending !== 4'b0 || cif.cmd_valid !== 1'b0) begin fails++; $display("FAIL rmid_clr got %b/%b want 0000/0", pending, cif.cmd_valid); end
    tests++; if (overrun !== 4'b0 || rsp_err !== 1'b0) begin fails++; $display("FAIL rmid_sticky got %b/%b want 0000/0", overrun, rsp_err); end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests++; if (done !== 4'b0 || pending !== 4'b0) begin fails++; $display("FAIL rmid_after c%0d got %b/%b want 0000/0000", c, done, pending); end
    end
  endtask

  task automatic test_random;
    logic [3:0]    m_pend, m_done, m_ovr, acc, comp;
    logic          m_err, c_we;
    int            m_phase, np, g, m_starve;  // phase: 0 idle, 1 command offered, 2 awaiting data
    logic [1:0]    m_src, c_ds;
    logic [AW-1:0] c_addr;
    logic [15:0]   c_din;
    logic          m_we [4];
    logic [AW-1:0] m_addr [4];
    logic [15:0]   m_din [4];
    logic [1:0]    m_ds [4];
    logic [63:0]   m_dout;
    @(negedge clk);
    req = 4'b0; cif.rsp_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_pend = '0; m_done = '0; m_ovr = '0; m_err = 1'b0; m_phase = 0; m_starve = 0;
    m_src = '0; c_we = 1'b0; c_addr = '0; c_din = '0; c_ds = '0; m_dout = '0;
    for (int k = 0; k < 4; k++) begin m_we[k] = 1'b0; m_addr[k] = '0; m_din[k] = '0; m_ds[k] = '0; end
    for (int c = 0; c < 600; c++) begin
      tests++; if (pending !== m_pend) begin fails++; $display("FAIL rnd_pending c%0d got %b want %b", c, pending, m_pend); end
      tests++; if (done !== m_done) begin fails++; $display("FAIL rnd_done c%0d got %b want %b", c, done, m_done); end
      tests++; if (overrun !== m_ovr) begin fails++; $display("FAIL rnd_overrun c%0d got %b want %b", c, overrun, m_ovr); end
      tests++; if (rsp_err !== m_err) begin fails++; $display("FAIL rnd_rsp_err c%0d got %b want %b", c, rsp_err, m_err); end
      tests++; if (dout !== m_dout) begin fails++; $display("FAIL rnd_dout c%0d got %h want %h", c, dout, m_dout); end
      tests++; if (cif.cmd_valid !== (m_phase == 1)) begin fails++; $display("FAIL rnd_valid c%0d got %b want %b", c, cif.cmd_valid, m_phase == 1); end
      if (m_phase == 1) begin
        tests++; if ({cif.cmd_src, cif.cmd_we, cif.cmd_ds} !== {m_src, c_we, c_ds}) begin fails++; $display("FAIL rnd_ctl c%0d got %b want %b", c, {cif.cmd_src, cif.cmd_we, cif.cmd_ds}, {m_src, c_we, c_ds}); end
        tests++; if ({cif.cmd_addr, cif.cmd_din} !== {c_addr, c_din}) begin fails++; $display("FAIL rnd_payload c%0d got %h want %h", c, {cif.cmd_addr, cif.cmd_din}, {c_addr, c_din}); end
      end
      // stimulus
      for (int i = 0; i < 4; i++) begin
        req[i] = ($urandom_range(0, 3) == 0);
        addr[i*AW +: AW] = AW'($urandom());
        din[i*16 +: 16]  = 16'($urandom());
      end
      we = 4'($urandom()); ds = 8'($urandom());
      cif.cmd_ready = ($urandom_range(0, 1) == 1);
      cif.rsp_valid = (m_phase == 2) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 60) == 0);
      cif.rsp_data  = 16'($urandom());
      // reference model: effect of the coming clock edge
      comp = '0; np = m_phase;
      if (m_phase == 1) begin
        if (cif.cmd_ready) begin
          if (c_we) begin comp[m_src] = 1'b1; np = 0; end
          else np = 2;
        end
      end else if (m_phase == 2) begin
        if (cif.rsp_valid) begin comp[m_src] = 1'b1; m_dout[int'(m_src)*16 +: 16] = cif.rsp_data; np = 0; end
      end else if (m_pend != 4'b0) begin
        g = 0;
        for (int i = 3; i >= 0; i--) if (m_pend[i]) g = i;
        if (m_pend[3] && m_starve >= RV) g = 3;
        if (g == 3) m_starve = 0;
        else if (m_pend[3]) m_starve = (m_starve + 1 > RV) ? RV : m_starve + 1;
        m_src = 2'(g); c_we = m_we[g]; c_addr = m_addr[g]; c_din = m_din[g]; c_ds = m_ds[g];
        np = 1;
      end
      if (!m_pend[3]) m_starve = 0;
      if (cif.rsp_valid && m_phase != 2) m_err = 1'b1;
      acc = '0;
      for (int i = 0; i < 4; i++) begin
        if (req[i]) begin
          if (!m_pend[i] || comp[i]) begin
            acc[i] = 1'b1;
            m_we[i] = we[i]; m_addr[i] = addr[i*AW +: AW]; m_din[i] = din[i*16 +: 16]; m_ds[i] = ds[i*2 +: 2];
          end else m_ovr[i] = 1'b1;
        end
      end
      m_pend = (m_pend & ~comp) | acc;
      m_done = comp;
      m_phase = np;
      @(negedge clk);
    end
    req = 4'b0; cif.rsp_valid = 1'b0;
  endtask

  initial begin
    req = '0; we = '0; addr = '0; din = '0; ds = '0;
    cif.cmd_ready = 1'b0; cif.rsp_valid = 1'b0; cif.rsp_data = '0;
    test_reset();
    test_single_read();
    test_all_writes();
    test_starvation();
    test_stall();
    test_overrun();
    test_rsp_err();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
